// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with parallel load, synchronous clear,
// wrap or saturate behaviour at the bounds, and terminal-count/boundary flags.
module param_updown_counter #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MOD_VAL   = 16,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    // One extra bit so MOD_VAL == 2**WIDTH is representable.
    localparam int unsigned EW = WIDTH + 1;
    localparam logic [EW-1:0]    MOD_EXT = EW'(MOD_VAL);
    localparam logic [EW-1:0]    MAX_EXT = EW'(MOD_VAL - 64'd1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MOD_VAL - 64'd1);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 1..32");
    end
    if (MOD_VAL < 2 || MOD_VAL > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("param_updown_counter: MOD_VAL must be 2..2**WIDTH");
    end
    if (RESET_VAL >= MOD_VAL) begin : g_bad_reset
        $error("param_updown_counter: RESET_VAL must be below MOD_VAL");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [EW-1:0]    count_ext;
    logic [EW-1:0]    load_ext;
    logic             at_top;
    logic             at_bot;

    assign count_ext = {1'b0, count_q};
    assign load_ext  = {1'b0, load_val};
    assign at_top    = (count_ext >= MAX_EXT);
    assign at_bot    = (count_q == '0);

    // Next-state: clr beats load beats en; a step past either bound is a boundary event.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = RST_W;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (load_ext >= MOD_EXT) ? MAX_W : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (!at_top) begin
                    count_d = WIDTH'(count_ext + EW'(1));
                end else begin
                    count_d = SATURATE ? MAX_W : '0;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    count_d = WIDTH'(count_ext - EW'(1));
                end else begin
                    count_d = SATURATE ? '0 : MAX_W;
                    wrap_d  = 1'b1;
                    ovf_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_W;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign wrap       = wrap_q;
    assign ovf_sticky = ovf_q;
    // Terminal count looks at the bound in the current direction, no latency.
    assign tc         = up_dn ? at_top : at_bot;

endmodule
